// File: rtl/multi_rate_divider.sv
// rtl/multi_rate_divider.sv - multi-channel programmable pulse divider
//
// Purpose: CHANNELS independent down-counting dividers. Each channel holds
// a period P, a counter C, a mode bit (0 periodic, 1 one-shot) and an armed
// flag. An armed, enabled channel emits a one-cycle registered pulse every
// P enabled clock edges; a one-shot channel disarms after its first pulse.
//
// Optional feature: define MULTI_RATE_DIV_WAVE_EN to add the wave output,
// a per-channel square wave that toggles on every pulse.
//
// Ports:
//   clock    in   1         rising-edge clock for all state
//   resetn   in   1         asynchronous active-low reset
//   enable   in   CHANNELS  per-channel count enable
//   wr_en    in   1         period write strobe
//   wr_sel   in   SEL_W     channel index for the write
//   wr_data  in   WIDTH     new period P (0 leaves the channel disarmed)
//   wr_mode  in   1         0 periodic, 1 one-shot
//   pulse    out  CHANNELS  registered one-cycle tick per channel
//   active   out  CHANNELS  channel armed flag
//   wave     out  CHANNELS  toggles on each pulse (MULTI_RATE_DIV_WAVE_EN only)

module multi_rate_divider #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] enable,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                wr_mode,
`ifdef MULTI_RATE_DIV_WAVE_EN
  output logic [CHANNELS-1:0] wave,
`endif
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] active
);

  // One extra bit so the range check works even when 2**SEL_W == CHANNELS.
  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

  logic sel_valid;
  assign sel_valid = ({1'b0, wr_sel} < CH_LIMIT);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] count_q;
    logic             mode_q;
    logic             armed_q;
    logic             pulse_q;
    logic             hit;

    assign hit = wr_en && sel_valid && (wr_sel == SEL_W'(i));

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        period_q <= '0;
        count_q  <= '0;
        mode_q   <= 1'b0;
        armed_q  <= 1'b0;
        pulse_q  <= 1'b0;
      end else if (hit) begin
        // A write wins over a coincident terminal count: no pulse this edge.
        period_q <= wr_data;
        count_q  <= wr_data;
        mode_q   <= wr_mode;
        armed_q  <= (wr_data != '0);
        pulse_q  <= 1'b0;
      end else if (enable[i] && armed_q) begin
        // Armed implies count_q >= 1, so the decrement never wraps.
        if (count_q == WIDTH'(1)) begin
          pulse_q <= 1'b1;
          count_q <= period_q;
          if (mode_q) begin
            armed_q <= 1'b0;
          end
        end else begin
          pulse_q <= 1'b0;
          count_q <= count_q - WIDTH'(1);
        end
      end else begin
        pulse_q <= 1'b0;
      end
    end

    assign pulse[i]  = pulse_q;
    assign active[i] = armed_q;

`ifdef MULTI_RATE_DIV_WAVE_EN
    logic wave_q;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        wave_q <= 1'b0;
      end else if (hit) begin
        wave_q <= 1'b0;
      end else if (enable[i] && armed_q && (count_q == WIDTH'(1))) begin
        wave_q <= ~wave_q;
      end
    end

    assign wave[i] = wave_q;
`endif
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// tb/tb_multi_rate_divider.sv - directed scoreboard bench for multi_rate_divider

module tb_multi_rate_divider;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 3;

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic [CHANNELS-1:0] enable = '0;
  logic                wr_en = 1'b0;
  logic [SEL_W-1:0]    wr_sel = '0;
  logic [WIDTH-1:0]    wr_data = '0;
  logic                wr_mode = 1'b0;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] active;
`ifdef MULTI_RATE_DIV_WAVE_EN
  logic [CHANNELS-1:0] wave;
`endif

  multi_rate_divider #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (enable),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .wr_mode (wr_mode),
`ifdef MULTI_RATE_DIV_WAVE_EN
    .wave    (wave),
`endif
    .pulse   (pulse),
    .active  (active)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [CHANNELS-1:0] p;
    logic [CHANNELS-1:0] a;
    string               tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int t1 = 0;

  task automatic chk(input string tag, input logic [CHANNELS-1:0] obs,
                     input logic [CHANNELS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Push expectation, clock one edge, then pop and compare away from the edge.
  task automatic tick(input logic [CHANNELS-1:0] ep, input logic [CHANNELS-1:0] ea,
                      input string tag);
    exp_t e;
    e.p = ep; e.a = ea; e.tag = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_pulse"}, pulse, e.p);
      chk({e.tag, "_active"}, active, e.a);
    end
  endtask

  task automatic wr(input int sel, input int data, input logic mode,
                    input logic [CHANNELS-1:0] ep, input logic [CHANNELS-1:0] ea,
                    input string tag);
    wr_en = 1'b1; wr_sel = SEL_W'(sel); wr_data = WIDTH'(data); wr_mode = mode;
    tick(ep, ea, tag);
    wr_en = 1'b0;
  endtask

  // Section with ch1 running P=2 periodic in the background: pulses on even edges.
  task automatic tick5(input logic ch0p, input string tag);
    logic ch1p;
    t1++;
    ch1p = (t1 % 2 == 0);
    tick({2'b00, ch1p, ch0p}, 4'b1111, tag);
  endtask

  task automatic wr5(input int sel, input int data, input logic ch0p, input string tag);
    wr_en = 1'b1; wr_sel = SEL_W'(sel); wr_data = WIDTH'(data); wr_mode = 1'b0;
    tick5(ch0p, tag);
    wr_en = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_pulse", pulse, 4'b0000);
    chk("reset_active", active, 4'b0000);
`ifdef MULTI_RATE_DIV_WAVE_EN
    chk("reset_wave", wave, 4'b0000);
`endif
    @(posedge clock); #1;
    resetn = 1'b1;
    enable = 4'b1111;
    tick(4'b0000, 4'b0000, "idle_after_reset");
    tick(4'b0000, 4'b0000, "idle_after_reset");

    // ch0 P=5 periodic
    wr(0, 5, 1'b0, 4'b0000, 4'b0001, "p5_write");
    for (int k = 1; k <= 12; k++) begin
      tick((k % 5 == 0) ? 4'b0001 : 4'b0000, 4'b0001, "p5_run");
`ifdef MULTI_RATE_DIV_WAVE_EN
      chk("p5_wave", wave & 4'b0001, ((k / 5) % 2 == 1) ? 4'b0001 : 4'b0000);
`endif
    end
    wr(0, 0, 1'b0, 4'b0000, 4'b0000, "p5_disarm");

    // ch1 P=3 one-shot
    wr(1, 3, 1'b1, 4'b0000, 4'b0010, "os_write");
    tick(4'b0000, 4'b0010, "os_c2");
    tick(4'b0000, 4'b0010, "os_c1");
    tick(4'b0010, 4'b0000, "os_fire");
    for (int k = 0; k < 20; k++) tick(4'b0000, 4'b0000, "os_quiet");

    // ch2 P=4 with an enable gap after 2 counted edges
    wr(2, 4, 1'b0, 4'b0000, 4'b0100, "gap_write");
    tick(4'b0000, 4'b0100, "gap_cnt");
    tick(4'b0000, 4'b0100, "gap_cnt");
    enable[2] = 1'b0;
    for (int k = 0; k < 10; k++) tick(4'b0000, 4'b0100, "gap_hold");
    enable[2] = 1'b1;
    tick(4'b0000, 4'b0100, "gap_resume1");
    tick(4'b0100, 4'b0100, "gap_resume2");
    tick(4'b0000, 4'b0100, "gap_next");
    tick(4'b0000, 4'b0100, "gap_next");
    tick(4'b0000, 4'b0100, "gap_next");
    tick(4'b0100, 4'b0100, "gap_next_fire");
    wr(2, 0, 1'b0, 4'b0000, 4'b0000, "gap_disarm");

    // ch3 P=0 then P=1
    wr(3, 0, 1'b0, 4'b0000, 4'b0000, "p0_write");
    for (int k = 0; k < 5; k++) tick(4'b0000, 4'b0000, "p0_quiet");
    wr(3, 1, 1'b0, 4'b0000, 4'b1000, "p1_write");
    for (int k = 0; k < 6; k++) tick(4'b1000, 4'b1000, "p1_every");
    enable[3] = 1'b0;
    tick(4'b0000, 4'b1000, "p1_disabled");
    enable[3] = 1'b1;
    tick(4'b1000, 4'b1000, "p1_reenabled");
    wr(3, 0, 1'b0, 4'b0000, 4'b0000, "p1_disarm");

    // Rewrite on terminal edge, invalid select, independence, reset mid-count
    wr(2, 200, 1'b0, 4'b0000, 4'b0100, "bg2_write");
    wr(3, 100, 1'b0, 4'b0000, 4'b1100, "bg3_write");
    wr(1, 2, 1'b0, 4'b0000, 4'b1110, "bg1_write");
    t1 = 0;
    wr5(0, 4, 1'b0, "rw_p4_write");
    for (int k = 1; k <= 7; k++) tick5(k == 4, "rw_p4_run");
    wr5(0, 6, 1'b0, "rw_terminal_write");
    for (int k = 1; k <= 6; k++) tick5(k == 6, "rw_p6_run");
    wr5(7, 2, 1'b0, "inv_write");
    for (int k = 2; k <= 6; k++) tick5(k == 6, "inv_p6_run");

    resetn = 1'b0;
    #1;
    chk("async_rst_pulse", pulse, 4'b0000);
    chk("async_rst_active", active, 4'b0000);
`ifdef MULTI_RATE_DIV_WAVE_EN
    chk("async_rst_wave", wave, 4'b0000);
`endif
    tick(4'b0000, 4'b0000, "rst_held");
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) tick(4'b0000, 4'b0000, "post_rst_quiet");
    wr(0, 2, 1'b0, 4'b0000, 4'b0001, "post_rst_write");
    tick(4'b0000, 4'b0001, "post_rst_c1");
    tick(4'b0001, 4'b0001, "post_rst_fire");

    chk("sb_drained", 4'(sb.size()), 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
